range_finder_stats: RTL and testbench
=====================================

// Module: range_finder_stats
// PURPOSE
//  Parametrised streaming range tracker: measures max, min, range and sample count over a
//  go..finish session of WIDTH-bit samples, in unsigned or two's-complement mode. Adds
//  per-sample valid qualification, a done pulse, and overflow-safe WIDTH+1 range.
//  Sits between the ui_in sample bus and the uo_out/uio_out result and status pins.
// PARAMETERS
//  WIDTH      8   sample width, >=2
//  CNT_WIDTH  8   sample counter width, >=2
//  SIGNED     0   0: unsigned compare; 1: two's-complement compare
// PORTS
//  clock         in   1            single clock, rising edge
//  reset         in   1            asynchronous, active-high
//  data_in       in   WIDTH        sample
//  sample_valid  in   1            data_in is a sample this cycle (RUN only)
//  go            in   1            start session; data_in on the go cycle is sample #1
//  finish        in   1            end session
//  range         out  WIDTH+1      max-min of last good session, always >=0
//  max_out       out  WIDTH        max of last good session
//  min_out       out  WIDTH        min of last good session
//  count         out  CNT_WIDTH    sample count of last good session (saturating)
//  count_sat     out  1            last good session's count saturated
//  done          out  1            1-cycle pulse: results just updated
//  busy          out  1            state==RUN
//  error         out  1            state==ERROR
// BEHAVIOUR
//  Reset (async, any time incl. mid-session): state IDLE; all outputs and internal
//   max/min/count/sat registers 0. Outputs change only on clock edges otherwise.
//  States IDLE, RUN, DONE, ERROR; registered, outputs decoded from state/registers.
//  IDLE: go&!finish -> RUN, cur_max=cur_min=data_in, cur_cnt=1, cur_sat=0.
//   finish (with or without go) -> ERROR. else stay. sample_valid ignored.
//  RUN: go (any finish) -> ERROR, session discarded, results unchanged.
//   else if sample_valid: cur_max/cur_min updated with data_in (compare per SIGNED);
//   cur_cnt+1, saturating at 2^CNT_WIDTH-1; cur_sat set on attempted increment past max.
//   finish&!go -> DONE; the sample on the finish cycle is included if sample_valid.
//   On that edge range/max_out/min_out/count/count_sat load final values.
//  DONE: done=1 for exactly this cycle; unconditionally -> IDLE (go/finish ignored).
//  ERROR: error=1; go&!finish -> RUN with same initialisation as IDLE; else stay.
//  Results (range..count_sat) hold between good sessions; never cleared except by reset.
//  Range arithmetic: extend max,min to WIDTH+1 bits (sign-extend if SIGNED, zero-extend
//   otherwise), subtract; result is non-negative and fits WIDTH+1 bits unsigned.
//   SIGNED=0 -> range MSB always 0.
//  Latency: finish edge -> results valid and done=1 in the following cycle.
//  Minimum session: go then finish next cycle -> count 1 (+1 if valid on finish), range>=0.
//  Back-to-back: go may be asserted in the cycle after DONE (state IDLE).
// TESTING
//  T1 SIGNED=0: go@10; valid 3,200,50; finish -> range 197, max 200, min 3, count 4,
//     done 1 cycle.
//  T2 SIGNED=1: go@8'h80(-128); valid 8'h7F; finish -> range 9'd255, max 8'h7F,
//     min 8'h80.
//  T3 finish in IDLE -> error=1 next cycle, results unchanged; go&!finish@5, finish ->
//     count 1, range 0, error 0.
//  T4 go during RUN -> ERROR, prior results (from T1) held; go&finish together in ERROR
//     -> stays ERROR.
//  T5 CNT_WIDTH=2: go + 4 valid samples + finish -> count 3, count_sat 1;
//     sample_valid=0 cycles not counted.
//  T6 assert reset mid-RUN between edges -> all outputs 0 immediately; busy 0;
//     next go starts fresh.

Source files
------------

// File: rtl/range_finder_stats_if.sv
// Sample/control bus into range_finder_stats and its result/status pins.
// data_in is taken as a sample on a clock edge only when sample_valid is high in RUN,
// or when go starts a session. There is no ready signal: every sample presented is accepted.
interface range_finder_stats_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     data_in;
  logic                 sample_valid;
  logic                 go;
  logic                 finish;
  logic [WIDTH:0]       range;
  logic [WIDTH-1:0]     max_out;
  logic [WIDTH-1:0]     min_out;
  logic [CNT_WIDTH-1:0] count;
  logic                 count_sat;
  logic                 done;
  logic                 busy;
  logic                 error;
  logic [1:0]           state_dbg;

  modport master (
    output data_in, sample_valid, go, finish,
    input  range, max_out, min_out, count, count_sat, done, busy, error, state_dbg
  );

  modport slave (
    input  data_in, sample_valid, go, finish,
    output range, max_out, min_out, count, count_sat, done, busy, error, state_dbg
  );
endinterface

// File: rtl/range_finder_stats.sv
// Streaming max/min/range/count tracker over a go..finish session, unsigned or signed.
// Results are published only when a session ends cleanly and hold until the next one.
module range_finder_stats #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int SIGNED    = 0
) (
  input  logic          clock,
  input  logic          reset,
  range_finder_stats_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERROR} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     cur_max_q, cur_max_d, cur_min_q, cur_min_d;
  logic [CNT_WIDTH-1:0] cur_cnt_q, cur_cnt_d;
  logic                 cur_sat_q, cur_sat_d;
  logic [WIDTH:0]       range_q, range_d;
  logic [WIDTH-1:0]     max_q, max_d, min_q, min_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;

  logic                 gt_max, lt_min, cnt_full;
  logic [WIDTH-1:0]     upd_max, upd_min, sel_max, sel_min;
  logic [CNT_WIDTH-1:0] upd_cnt, sel_cnt;
  logic                 upd_sat, sel_sat;
  logic [WIDTH:0]       ext_max, ext_min;

  always_comb begin
    if (SIGNED != 0) begin
      gt_max = $signed(bus.data_in) > $signed(cur_max_q);
      lt_min = $signed(bus.data_in) < $signed(cur_min_q);
    end else begin
      gt_max = bus.data_in > cur_max_q;
      lt_min = bus.data_in < cur_min_q;
    end
    cnt_full = (cur_cnt_q == {CNT_WIDTH{1'b1}});
    upd_max  = gt_max ? bus.data_in : cur_max_q;
    upd_min  = lt_min ? bus.data_in : cur_min_q;
    upd_cnt  = cnt_full ? cur_cnt_q : cur_cnt_q + CNT_WIDTH'(1);
    upd_sat  = cur_sat_q | cnt_full;
    // Values as they stand after this cycle's sample, used when finish closes the session.
    sel_max  = bus.sample_valid ? upd_max : cur_max_q;
    sel_min  = bus.sample_valid ? upd_min : cur_min_q;
    sel_cnt  = bus.sample_valid ? upd_cnt : cur_cnt_q;
    sel_sat  = bus.sample_valid ? upd_sat : cur_sat_q;
    ext_max  = {(SIGNED != 0) & sel_max[WIDTH-1], sel_max};
    ext_min  = {(SIGNED != 0) & sel_min[WIDTH-1], sel_min};
  end

  always_comb begin
    state_d   = state_q;
    cur_max_d = cur_max_q;
    cur_min_d = cur_min_q;
    cur_cnt_d = cur_cnt_q;
    cur_sat_d = cur_sat_q;
    range_d   = range_q;
    max_d     = max_q;
    min_d     = min_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (bus.go && !bus.finish) begin
          state_d   = S_RUN;
          cur_max_d = bus.data_in;
          cur_min_d = bus.data_in;
          cur_cnt_d = CNT_WIDTH'(1);
          cur_sat_d = 1'b0;
        end else if (bus.finish) begin
          state_d = S_ERROR;
        end
      end
      S_RUN: begin
        if (bus.go) begin
          state_d = S_ERROR;
        end else begin
          if (bus.sample_valid) begin
            cur_max_d = upd_max;
            cur_min_d = upd_min;
            cur_cnt_d = upd_cnt;
            cur_sat_d = upd_sat;
          end
          if (bus.finish) begin
            state_d = S_DONE;
            range_d = ext_max - ext_min;
            max_d   = sel_max;
            min_d   = sel_min;
            cnt_d   = sel_cnt;
            sat_d   = sel_sat;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_max_q <= '0;
      cur_min_q <= '0;
      cur_cnt_q <= '0;
      cur_sat_q <= 1'b0;
      range_q   <= '0;
      max_q     <= '0;
      min_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_max_q <= cur_max_d;
      cur_min_q <= cur_min_d;
      cur_cnt_q <= cur_cnt_d;
      cur_sat_q <= cur_sat_d;
      range_q   <= range_d;
      max_q     <= max_d;
      min_q     <= min_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign bus.range     = range_q;
  assign bus.max_out   = max_q;
  assign bus.min_out   = min_q;
  assign bus.count     = cnt_q;
  assign bus.count_sat = sat_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.error     = (state_q == S_ERROR);
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_range_finder_stats.sv
// Drives one stimulus stream into unsigned, signed and 2-bit-counter instances of
// range_finder_stats and scores every done pulse against expected session results.
module tb_range_finder_stats;
  typedef struct packed {
    logic [8:0] ru;
    logic [7:0] mxu;
    logic [7:0] mnu;
    logic [7:0] cu;
    logic       su;
    logic [8:0] rs;
    logic [7:0] mxs;
    logic [7:0] mns;
    logic [1:0] cc;
    logic       sc;
  } exp_t;
  localparam int EW = $bits(exp_t);

  typedef struct {
    int         n;
    logic [7:0] d[8];
    logic [7:0] vm;
    exp_t       e;
  } sess_t;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       sample_valid, go, finish;

  logic [EW-1:0] exp_q[$];
  exp_t          last_exp;
  int            n_vec = 0;
  int            n_err = 0;
  logic          prev_done = 1'b0;
  sess_t         tbl[6];

  range_finder_stats_if #(.WIDTH(8), .CNT_WIDTH(8)) if_u ();
  range_finder_stats_if #(.WIDTH(8), .CNT_WIDTH(8)) if_s ();
  range_finder_stats_if #(.WIDTH(8), .CNT_WIDTH(2)) if_c ();

  assign if_u.data_in = data_in;  assign if_u.sample_valid = sample_valid;
  assign if_u.go      = go;       assign if_u.finish       = finish;
  assign if_s.data_in = data_in;  assign if_s.sample_valid = sample_valid;
  assign if_s.go      = go;       assign if_s.finish       = finish;
  assign if_c.data_in = data_in;  assign if_c.sample_valid = sample_valid;
  assign if_c.go      = go;       assign if_c.finish       = finish;

  range_finder_stats #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(0)) dut_u (.clock(clock), .reset(reset), .bus(if_u));
  range_finder_stats #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(1)) dut_s (.clock(clock), .reset(reset), .bus(if_s));
  range_finder_stats #(.WIDTH(8), .CNT_WIDTH(2), .SIGNED(0)) dut_c (.clock(clock), .reset(reset), .bus(if_c));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_range_u"}, 32'(if_u.range), 32'(last_exp.ru));
    chk({tag, "_max_u"}, 32'(if_u.max_out), 32'(last_exp.mxu));
    chk({tag, "_min_u"}, 32'(if_u.min_out), 32'(last_exp.mnu));
    chk({tag, "_count_u"}, 32'(if_u.count), 32'(last_exp.cu));
    chk({tag, "_range_s"}, 32'(if_s.range), 32'(last_exp.rs));
    chk({tag, "_count_c"}, 32'({if_c.count_sat, if_c.count}), 32'({last_exp.sc, last_exp.cc}));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_u"}, 32'({if_u.range, if_u.max_out, if_u.min_out}), 32'd0);
    chk({tag, "_u_cnt"}, 32'({if_u.count, if_u.count_sat}), 32'd0);
    chk({tag, "_u_status"}, 32'({if_u.done, if_u.busy, if_u.error, if_u.state_dbg}), 32'd0);
    chk({tag, "_s"}, 32'({if_s.range, if_s.max_out, if_s.min_out}), 32'd0);
    chk({tag, "_c"}, 32'({if_c.count, if_c.count_sat, if_c.busy}), 32'd0);
  endtask

  // driver tasks
  task automatic idle();
    go           = 1'b0;
    finish       = 1'b0;
    sample_valid = 1'($urandom_range(0, 1));
    data_in      = 8'($urandom_range(0, 255));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_sess(input sess_t s);
    go = 1'b1; finish = 1'b0; data_in = s.d[0];
    sample_valid = 1'($urandom_range(0, 1));
    step();
    for (int i = 1; i < s.n; i++) begin
      go           = 1'b0;
      sample_valid = s.vm[i];
      data_in      = s.d[i];
      finish       = (i == s.n - 1);
      if (finish) exp_q.push_back(s.e);
      step();
    end
    // DONE cycle: go/finish here must be ignored
    go = 1'($urandom_range(0, 1)); finish = 1'($urandom_range(0, 1));
    sample_valid = 1'($urandom_range(0, 1)); data_in = 8'($urandom_range(0, 255));
    step();
    chk("idle_after_done", 32'({if_u.busy, if_u.error, if_u.done, if_u.state_dbg}), 32'd0);
    idle();
  endtask

  function automatic sess_t mk(input int n, input logic [63:0] dv, input logic [7:0] vm, input exp_t e);
    sess_t s;
    s.n = n;
    for (int i = 0; i < 8; i++) s.d[i] = dv[8*i +: 8];
    s.vm = vm;
    s.e  = e;
    return s;
  endfunction

  function automatic exp_t model(input sess_t s);
    exp_t       e;
    logic [7:0] umx, umn, smx, smn;
    int         cnt;
    umx = s.d[0]; umn = s.d[0]; smx = s.d[0]; smn = s.d[0]; cnt = 1;
    for (int i = 1; i < s.n; i++) begin
      if (s.vm[i]) begin
        if (s.d[i] > umx) umx = s.d[i];
        if (s.d[i] < umn) umn = s.d[i];
        if ($signed(s.d[i]) > $signed(smx)) smx = s.d[i];
        if ($signed(s.d[i]) < $signed(smn)) smn = s.d[i];
        cnt++;
      end
    end
    e.ru  = {1'b0, umx} - {1'b0, umn};
    e.mxu = umx;
    e.mnu = umn;
    e.cu  = 8'(cnt);
    e.su  = 1'b0;
    e.rs  = {smx[7], smx} - {smn[7], smn};
    e.mxs = smx;
    e.mns = smn;
    e.cc  = (cnt > 3) ? 2'd3 : 2'(cnt);
    e.sc  = (cnt > 3);
    return e;
  endfunction

  // scoreboard: one expected record per done pulse
  always @(negedge clock) begin
    if (!reset && if_u.done) begin
      exp_t e;
      chk("done_pulse_width", 32'(prev_done), 32'd0);
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      chk("done_all", 32'({if_s.done, if_c.done, if_u.busy, if_u.error}), 32'b1100);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        last_exp = e;
        chk("range_u", 32'(if_u.range), 32'(e.ru));
        chk("max_u", 32'(if_u.max_out), 32'(e.mxu));
        chk("min_u", 32'(if_u.min_out), 32'(e.mnu));
        chk("count_u", 32'({if_u.count_sat, if_u.count}), 32'({e.su, e.cu}));
        chk("range_s", 32'(if_s.range), 32'(e.rs));
        chk("max_s", 32'(if_s.max_out), 32'(e.mxs));
        chk("min_s", 32'(if_s.min_out), 32'(e.mns));
        chk("count_c", 32'({if_c.count_sat, if_c.count}), 32'({e.sc, e.cc}));
      end
    end
    prev_done = if_u.done;
  end

  initial begin
    sess_t r;
    tbl[0] = mk(5, 64'h00000000_32C8030A, 8'b0000_1110,
                exp_t'{9'd197, 8'd200, 8'd3, 8'd4, 1'b0, 9'd106, 8'd50, 8'hC8, 2'd3, 1'b1});
    tbl[1] = mk(2, 64'h00000000_00007F80, 8'b0000_0010,
                exp_t'{9'd1, 8'h80, 8'h7F, 8'd2, 1'b0, 9'd255, 8'h7F, 8'h80, 2'd2, 1'b0});
    tbl[2] = mk(2, 64'h00000000_00003305, 8'b0000_0000,
                exp_t'{9'd0, 8'd5, 8'd5, 8'd1, 1'b0, 9'd0, 8'd5, 8'd5, 2'd1, 1'b0});
    tbl[3] = mk(4, 64'h00000000_807FFF00, 8'b0000_1110,
                exp_t'{9'd255, 8'hFF, 8'h00, 8'd4, 1'b0, 9'd255, 8'h7F, 8'h80, 2'd3, 1'b1});
    tbl[4] = mk(5, 64'h00000001_09FA0764, 8'b0001_0100,
                exp_t'{9'd249, 8'hFA, 8'h01, 8'd3, 1'b0, 9'd106, 8'h64, 8'hFA, 2'd3, 1'b0});
    tbl[5] = mk(3, 64'h00000000_00F0F0F0, 8'b0000_0110,
                exp_t'{9'd0, 8'hF0, 8'hF0, 8'd3, 1'b0, 9'd0, 8'hF0, 8'hF0, 2'd3, 1'b0});
    last_exp = '0;

    reset = 1'b0;
    idle();
    #1 reset = 1'b1;
    #1 chk_zero("reset");
    step();
    reset = 1'b0;
    step();

    // T1 unsigned session, then T4 go mid-RUN keeps T1 results
    run_sess(tbl[0]);
    go = 1'b1; finish = 1'b0; data_in = 8'd1; sample_valid = 1'b0;
    step();
    go = 1'b0; sample_valid = 1'b1; data_in = 8'd255;
    step();
    chk("t4_busy", 32'(if_u.busy), 32'd1);
    go = 1'b1; finish = 1'($urandom_range(0, 1)); data_in = 8'd0;
    step();
    chk("t4_error", 32'({if_u.error, if_u.busy, if_u.done}), 32'b100);
    chk_results("t4_held");
    go = 1'b1; finish = 1'b1;
    step();
    chk("t4_go_finish_stays", 32'({if_u.error, if_u.busy}), 32'b10);
    go = 1'b0; finish = 1'b1;
    step();
    chk("t4_finish_stays", 32'({if_u.error, if_u.busy}), 32'b10);
    chk_results("t4_held2");

    // T2 from ERROR, then T3 finish while IDLE
    run_sess(tbl[1]);
    go = 1'($urandom_range(0, 1)); finish = 1'b1;
    step();
    chk("t3_error", 32'({if_u.error, if_u.busy}), 32'b10);
    chk_results("t3_held");
    idle();
    run_sess(tbl[2]);
    chk("t3_error_cleared", 32'(if_u.error), 32'd0);

    // back-to-back table sessions
    for (int i = 3; i < 6; i++) run_sess(tbl[i]);

    for (int k = 0; k < 20; k++) begin
      r.n = $urandom_range(2, 8);
      for (int i = 0; i < 8; i++) r.d[i] = 8'($urandom_range(0, 255));
      r.vm = 8'($urandom_range(0, 255));
      r.e  = model(r);
      run_sess(r);
      if ($urandom_range(0, 1) == 1) step();
    end

    // T6 asynchronous reset between edges in RUN
    go = 1'b1; finish = 1'b0; data_in = 8'h40;
    step();
    go = 1'b0; sample_valid = 1'b1; data_in = 8'h90;
    @(posedge clock);
    #3 reset = 1'b1;
    #1 chk_zero("t6_reset");
    last_exp = '0;
    step();
    reset = 1'b0;
    idle();
    step();
    chk_results("t6_after");
    run_sess(tbl[0]);

    repeat (2) step();
    chk("pending_expect", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
